tri_cull_stage: RTL and testbench

//  Triangle setup/cull stage between draw_triangle_pipe (upstream) and draw_triangle (downstream).

---
 rtl/tri_cull_stage_if.sv | 21 ++
 rtl/tri_cull_stage.sv | 144 ++++++++++++++
 tb/tb_tri_cull_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tri_cull_stage_if.sv
// Triangle link between pipeline stages: nine vertex coordinates, colour and a
// draw_en/draw_done handshake. The master supplies the triangle and the slave answers with draw_done.
interface tri_cull_stage_if #(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3
);
  logic signed [WIDTH-1:0]  ax, ay, az, bx, by, bz, cx, cy, cz;
  logic [COLOUR_WIDTH-1:0]  colour;
  logic                     draw_en;
  logic                     draw_done;

  modport master (
    output ax, ay, az, bx, by, bz, cx, cy, cz, colour, draw_en,
    input  draw_done
  );

  modport slave (
    input  ax, ay, az, bx, by, bz, cx, cy, cz, colour, draw_en,
    output draw_done
  );
endinterface

// File: rtl/tri_cull_stage.sv
// Triangle setup/cull stage: captures one triangle and computes twice its signed area.
// Degenerate, back-facing, off-screen and behind-camera triangles are dropped. All others go to the drawer unchanged.
module tri_cull_stage #(
  parameter int WIDTH        = 32,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cull_back,
  tri_cull_stage_if.slave      up,
  tri_cull_stage_if.master     dn,
  output logic [15:0]          tri_in_count,
  output logic [15:0]          tri_cull_count
);

  localparam int D_W = WIDTH + 1;
  localparam int P_W = 2 * WIDTH + 2;
  localparam int A_W = 2 * WIDTH + 3;
  localparam logic signed [D_W-1:0] L_SW = D_W'(SCREEN_W);
  localparam logic signed [D_W-1:0] L_SH = D_W'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE, S_DIFF, S_MUL, S_DECIDE, S_EMIT, S_DONE, S_RELEASE
  } state_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] z;
  } vtx_t;

  state_t                   r_state, w_next;
  vtx_t                     r_v   [3];
  vtx_t                     r_out [3];
  logic [COLOUR_WIDTH-1:0]  r_colour, r_out_colour;
  logic                     r_cull_back;
  logic [15:0]              r_in_count, r_cull_count;
  logic signed [D_W-1:0]    r_e1x, r_e1y, r_e2x, r_e2y;
  logic signed [P_W-1:0]    r_p1, r_p2;

  logic                     w_capture, w_load, w_cull_hit, w_cull;
  logic signed [A_W-1:0]    w_area2;
  logic                     w_x_left, w_x_right, w_y_above, w_y_below, w_z_behind;

  // The products are sign-extended to full width first, so area2 is exact for any input coordinates.
  assign w_area2 = A_W'(r_p1) - A_W'(r_p2);

  assign w_x_left   = r_v[0].x[WIDTH-1] & r_v[1].x[WIDTH-1] & r_v[2].x[WIDTH-1];
  assign w_y_above  = r_v[0].y[WIDTH-1] & r_v[1].y[WIDTH-1] & r_v[2].y[WIDTH-1];
  assign w_z_behind = r_v[0].z[WIDTH-1] & r_v[1].z[WIDTH-1] & r_v[2].z[WIDTH-1];
  assign w_x_right  = (D_W'($signed(r_v[0].x)) >= L_SW) && (D_W'($signed(r_v[1].x)) >= L_SW)
                   && (D_W'($signed(r_v[2].x)) >= L_SW);
  assign w_y_below  = (D_W'($signed(r_v[0].y)) >= L_SH) && (D_W'($signed(r_v[1].y)) >= L_SH)
                   && (D_W'($signed(r_v[2].y)) >= L_SH);

  assign w_cull = (w_area2 == '0) || (r_cull_back && w_area2[A_W-1])
               || w_x_left || w_x_right || w_y_above || w_y_below || w_z_behind;

  always_comb begin
    // NOTE: give every combinational output a default first, so no path leaves it unassigned and no latch is inferred.
    w_next     = r_state;
    w_capture  = 1'b0;
    w_load     = 1'b0;
    w_cull_hit = 1'b0;
    case (r_state)
      S_IDLE:    if (up.draw_en) begin
                   w_capture = 1'b1;
                   w_next    = S_DIFF;
                 end
      S_DIFF:    w_next = S_MUL;
      S_MUL:     w_next = S_DECIDE;
      S_DECIDE:  if (w_cull) begin
                   w_cull_hit = 1'b1;
                   w_next     = S_DONE;
                 end else begin
                   w_load = 1'b1;
                   w_next = S_EMIT;
                 end
      S_EMIT:    if (dn.draw_done) w_next = S_DONE;
      S_DONE:    w_next = S_RELEASE;
      S_RELEASE: if (!up.draw_en) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_colour     <= '0;
      r_out_colour <= '0;
      r_cull_back  <= 1'b0;
      r_in_count   <= '0;
      r_cull_count <= '0;
      for (int i = 0; i < 3; i++) begin
        r_v[i]   <= '0;
        r_out[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every register in this block take its value from the pre-edge state.
      r_state <= w_next;
      if (w_capture) begin
        r_v[0]      <= '{x: up.ax, y: up.ay, z: up.az};
        r_v[1]      <= '{x: up.bx, y: up.by, z: up.bz};
        r_v[2]      <= '{x: up.cx, y: up.cy, z: up.cz};
        r_colour    <= up.colour;
        r_cull_back <= cull_back;
        if (r_in_count != 16'hFFFF) r_in_count <= r_in_count + 16'd1;
      end
      if (w_load) begin
        r_out        <= r_v;
        r_out_colour <= r_colour;
      end
      if (w_cull_hit && (r_cull_count != 16'hFFFF)) r_cull_count <= r_cull_count + 16'd1;
    end
  end

  // NOTE: these pipeline registers are only read in states that the FSM reaches after loading them, so they have no reset.
  always_ff @(posedge clock) begin
    r_e1x <= D_W'($signed(r_v[1].x)) - D_W'($signed(r_v[0].x));
    r_e1y <= D_W'($signed(r_v[1].y)) - D_W'($signed(r_v[0].y));
    r_e2x <= D_W'($signed(r_v[2].x)) - D_W'($signed(r_v[0].x));
    r_e2y <= D_W'($signed(r_v[2].y)) - D_W'($signed(r_v[0].y));
    r_p1  <= P_W'(r_e1x) * P_W'(r_e2y);
    r_p2  <= P_W'(r_e2x) * P_W'(r_e1y);
  end

  assign up.draw_done    = (r_state == S_DONE);
  assign dn.draw_en      = (r_state == S_EMIT);
  assign dn.ax           = r_out[0].x;
  assign dn.ay           = r_out[0].y;
  assign dn.az           = r_out[0].z;
  assign dn.bx           = r_out[1].x;
  assign dn.by           = r_out[1].y;
  assign dn.bz           = r_out[1].z;
  assign dn.cx           = r_out[2].x;
  assign dn.cy           = r_out[2].y;
  assign dn.cz           = r_out[2].z;
  assign dn.colour       = r_out_colour;
  assign tri_in_count    = r_in_count;
  assign tri_cull_count  = r_cull_count;

endmodule

// File: tb/tb_tri_cull_stage.sv
// Self-checking bench for tri_cull_stage: directed cases from the cull rules plus
// randomised triangles checked against an area/visibility model with wide arithmetic.
module tb_tri_cull_stage;

  localparam int WIDTH = 32;
  localparam int CW    = 3;

  typedef struct {
    int ax, ay, az, bx, by, bz, cx, cy, cz;
    logic [CW-1:0] colour;
  } tri_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cull_back = 1'b0;
  logic [15:0] tri_in_count, tri_cull_count;

  tri_cull_stage_if #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW)) up_if ();
  tri_cull_stage_if #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW)) dn_if ();

  tri_cull_stage #(.WIDTH(WIDTH), .COLOUR_WIDTH(CW), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock          (clock),
    .reset          (reset),
    .cull_back      (cull_back),
    .up             (up_if),
    .dn             (dn_if),
    .tri_in_count   (tri_in_count),
    .tri_cull_count (tri_cull_count)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_err  = 0;
  int exp_in = 0;
  int exp_cull = 0;

  function automatic tri_t mk(int ax, int ay, int az, int bx, int by, int bz,
                              int cx, int cy, int cz, int col);
    tri_t t;
    t.ax = ax; t.ay = ay; t.az = az;
    t.bx = bx; t.by = by; t.bz = bz;
    t.cx = cx; t.cy = cy; t.cz = cz;
    t.colour = CW'(col);
    return t;
  endfunction

  // Reference: exact doubled area in 128-bit arithmetic, then the visibility rules.
  function automatic bit model_cull(tri_t t, bit cb);
    logic signed [127:0] ax, ay, bx, by, cx, cy, area;
    ax = t.ax; ay = t.ay; bx = t.bx; by = t.by; cx = t.cx; cy = t.cy;
    area = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
    if (area == 0) return 1'b1;
    if (cb && area < 0) return 1'b1;
    if (t.ax < 0 && t.bx < 0 && t.cx < 0) return 1'b1;
    if (t.ax >= 160 && t.bx >= 160 && t.cx >= 160) return 1'b1;
    if (t.ay < 0 && t.by < 0 && t.cy < 0) return 1'b1;
    if (t.ay >= 120 && t.by >= 120 && t.cy >= 120) return 1'b1;
    if (t.az < 0 && t.bz < 0 && t.cz < 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_tri(input tri_t t);
    up_if.ax = t.ax; up_if.ay = t.ay; up_if.az = t.az;
    up_if.bx = t.bx; up_if.by = t.by; up_if.bz = t.bz;
    up_if.cx = t.cx; up_if.cy = t.cy; up_if.cz = t.cz;
    up_if.colour = t.colour;
  endtask

  // One full transaction: request, pipeline latency, cull/draw outcome, release and counters.
  task automatic do_triangle(input tri_t t, input bit cb, input bit exp_c, input int draw_delay,
                             input int hold, input bit spurious, input bit mid_drop, input string tag);
    logic [6*WIDTH+CW-1:0] want_out;
    want_out = {t.ax, t.ay, t.bx, t.by, t.cx, t.cy, t.colour};
    @(negedge clock);
    drive_tri(t);
    cull_back = cb;
    up_if.draw_en = 1'b1;
    @(posedge clock);
    if (exp_in < 16'hFFFF) exp_in++;
    if (exp_c && exp_cull < 16'hFFFF) exp_cull++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_vec++;
      if (dn_if.draw_en !== 1'b0 || up_if.draw_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s latency k=%0d: out_draw_en=%b in_draw_done=%b want 0/0", tag, k,
                 dn_if.draw_en, up_if.draw_done);
      end
      if (k == 0 && spurious) dn_if.draw_done = 1'b1;
      if (k == 1) dn_if.draw_done = 1'b0;
      if (k == 0 && mid_drop) begin
        up_if.draw_en = 1'b0;
        cull_back = ~cb;
        up_if.ax = $urandom; up_if.by = $urandom; up_if.cy = $urandom; up_if.az = -7;
      end
    end
    @(negedge clock);
    if (exp_c) begin
      n_vec++;
      if (up_if.draw_done !== 1'b1 || dn_if.draw_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s cull pulse: in_draw_done=%b out_draw_en=%b want 1/0", tag,
                 up_if.draw_done, dn_if.draw_en);
      end
    end else begin
      n_vec++;
      if (dn_if.draw_en !== 1'b1 || up_if.draw_done !== 1'b0) begin
        n_err++;
        $display("FAIL %s emit: out_draw_en=%b in_draw_done=%b want 1/0", tag,
                 dn_if.draw_en, up_if.draw_done);
      end
      for (int d = 0; d <= draw_delay; d++) begin
        if (d > 0) @(negedge clock);
        n_vec++;
        if ({dn_if.ax, dn_if.ay, dn_if.bx, dn_if.by, dn_if.cx, dn_if.cy, dn_if.colour} !== want_out
            || dn_if.draw_en !== 1'b1) begin
          n_err++;
          $display("FAIL %s out data d=%0d: got %h en=%b want %h en=1", tag, d,
                   {dn_if.ax, dn_if.ay, dn_if.bx, dn_if.by, dn_if.cx, dn_if.cy, dn_if.colour},
                   dn_if.draw_en, want_out);
        end
      end
      dn_if.draw_done = 1'b1;
      @(negedge clock);
      dn_if.draw_done = 1'b0;
      n_vec++;
      if (up_if.draw_done !== 1'b1 || dn_if.draw_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s done pulse: in_draw_done=%b out_draw_en=%b want 1/0", tag,
                 up_if.draw_done, dn_if.draw_en);
      end
    end
    @(negedge clock);
    n_vec++;
    if (up_if.draw_done !== 1'b0 || dn_if.draw_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s pulse width: in_draw_done=%b out_draw_en=%b want 0/0", tag,
               up_if.draw_done, dn_if.draw_en);
    end
    repeat (hold) begin
      @(negedge clock);
      n_vec++;
      if (up_if.draw_done !== 1'b0 || dn_if.draw_en !== 1'b0) begin
        n_err++;
        $display("FAIL %s hold: in_draw_done=%b out_draw_en=%b want 0/0", tag,
                 up_if.draw_done, dn_if.draw_en);
      end
    end
    up_if.draw_en = 1'b0;
    @(negedge clock);
    n_vec++;
    if (tri_in_count !== 16'(exp_in) || tri_cull_count !== 16'(exp_cull)) begin
      n_err++;
      $display("FAIL %s counters: in=%0d cull=%0d want %0d/%0d", tag, tri_in_count,
               tri_cull_count, exp_in, exp_cull);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_vec++;
    if (dn_if.draw_en !== 1'b0 || up_if.draw_done !== 1'b0 || tri_in_count !== 16'd0
        || tri_cull_count !== 16'd0 || dn_if.ax !== '0 || dn_if.cy !== '0 || dn_if.colour !== '0) begin
      n_err++;
      $display("FAIL reset state: en=%b done=%b in=%0d cull=%0d ax=%0d want all 0", dn_if.draw_en,
               up_if.draw_done, tri_in_count, tri_cull_count, dn_if.ax);
    end
    reset = 1'b1;
  endtask

  task automatic test_ccw;
    do_triangle(mk(10, 10, 5, 50, 10, 5, 10, 40, 5, 5), 1'b1, 1'b0, 2, 0, 1'b0, 1'b0, "ccw");
    n_vec++;
    if (tri_in_count !== 16'd1 || tri_cull_count !== 16'd0) begin
      n_err++;
      $display("FAIL ccw counts: in=%0d cull=%0d want 1/0", tri_in_count, tri_cull_count);
    end
  endtask

  task automatic test_backface;
    do_triangle(mk(10, 10, 5, 10, 40, 5, 50, 10, 5, 2), 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, "cw_cull");
    do_triangle(mk(10, 10, 5, 10, 40, 5, 50, 10, 5, 2), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, "cw_draw");
  endtask

  task automatic test_offscreen;
    do_triangle(mk(0, 0, 5, 20, 20, 5, 40, 40, 5, 1), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "collinear");
    do_triangle(mk(160, 10, 5, 170, 50, 5, 200, 90, 5, 1), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "right");
    do_triangle(mk(159, 10, 5, 170, 50, 5, 200, 90, 5, 1), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, "right_edge");
    do_triangle(mk(-5, 10, 5, 10, 50, 5, 20, 10, 5, 6), 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, "partial");
    do_triangle(mk(-5, 10, 5, -1, 50, 5, -20, 10, 5, 6), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "left");
    do_triangle(mk(10, 120, 5, 50, 130, 5, 20, 140, 5, 3), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "below");
    do_triangle(mk(10, 119, 5, 50, 130, 5, 20, 140, 5, 3), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, "below_edge");
    do_triangle(mk(10, -1, 5, 50, -30, 5, 20, -9, 5, 3), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "above");
    do_triangle(mk(10, 10, -1, 50, 10, -1, 10, 40, -1, 4), 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, "behind");
    do_triangle(mk(10, 10, -1, 50, 10, 0, 10, 40, -1, 4), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, "z_partial");
  endtask

  task automatic test_extreme;
    int lo, hi;
    lo = int'(32'h8000_0000);
    hi = int'(32'h7FFF_FFFF);
    do_triangle(mk(lo, 0, 1, hi, 0, 1, 0, hi, 1, 7), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, "extreme_ccw");
    do_triangle(mk(lo, 0, 1, 0, hi, 1, hi, 0, 1, 7), 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, "extreme_cw");
  endtask

  task automatic test_hold;
    do_triangle(mk(10, 10, 5, 50, 10, 5, 10, 40, 5, 5), 1'b1, 1'b0, 0, 20, 1'b0, 1'b0, "hold_draw");
    do_triangle(mk(0, 0, 5, 20, 20, 5, 40, 40, 5, 5), 1'b1, 1'b1, 0, 20, 1'b0, 1'b0, "hold_cull");
  endtask

  task automatic test_reset_emit;
    @(negedge clock);
    drive_tri(mk(10, 10, 5, 50, 10, 5, 10, 40, 5, 5));
    cull_back = 1'b1;
    up_if.draw_en = 1'b1;
    repeat (4) @(negedge clock);
    n_vec++;
    if (dn_if.draw_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_emit pre: out_draw_en=%b want 1", dn_if.draw_en);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (dn_if.draw_en !== 1'b0 || up_if.draw_done !== 1'b0 || tri_in_count !== 16'd0
        || tri_cull_count !== 16'd0 || dn_if.ax !== '0 || dn_if.bx !== '0 || dn_if.colour !== '0) begin
      n_err++;
      $display("FAIL reset_emit async: en=%b done=%b in=%0d ax=%0d bx=%0d want all 0", dn_if.draw_en,
               up_if.draw_done, tri_in_count, dn_if.ax, dn_if.bx);
    end
    @(negedge clock);
    up_if.draw_en = 1'b0;
    reset = 1'b1;
    exp_in = 0;
    exp_cull = 0;
    do_triangle(mk(30, 30, 2, 90, 40, 2, 40, 100, 2, 1), 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, "after_reset");
  endtask

  function automatic int rnd_coord();
    if ($urandom_range(0, 9) == 0) return int'($urandom);
    return int'($urandom_range(0, 300)) - 60;
  endfunction

  task automatic test_random;
    tri_t t;
    bit   cb;
    for (int n = 0; n < 60; n++) begin
      t = mk(rnd_coord(), rnd_coord(), int'($urandom_range(0, 20)) - 4,
             rnd_coord(), rnd_coord(), int'($urandom_range(0, 20)) - 4,
             rnd_coord(), rnd_coord(), int'($urandom_range(0, 20)) - 4,
             int'($urandom_range(0, 7)));
      if ($urandom_range(0, 7) == 0) begin
        t.cx = t.ax + 2 * (t.bx - t.ax);
        t.cy = t.ay + 2 * (t.by - t.ay);
      end
      cb = 1'($urandom_range(0, 1));
      do_triangle(t, cb, model_cull(t, cb), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, "random");
    end
  endtask

  initial begin
    up_if.draw_en   = 1'b0;
    dn_if.draw_done = 1'b0;
    drive_tri(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_ccw();
    test_backface();
    test_offscreen();
    test_extreme();
    test_hold();
    test_reset_emit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
